// File: rtl/tow_pkg.sv
// ---------------------------------------------------------------------------
// tow_pkg : constants shared by all input_conditioner instances
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tow_pkg;

   localparam int TOW_SYNC_STAGES     = 2;
   localparam int TOW_DEBOUNCE_CYCLES = 4;

endpackage

`default_nettype wire

// File: rtl/input_conditioner_channel.sv
// ---------------------------------------------------------------------------
// input_conditioner_channel : one channel of the conditioner. It contains
// the sync chain, the debounce counter and the registered level/edge outputs.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module input_conditioner_channel
   import tow_pkg::*;
#(
   parameter int STAGES          = TOW_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = TOW_DEBOUNCE_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic in,
   output logic level,
   output logic rise,
   output logic fall
);

   localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   generate
      if (STAGES < 2) begin : g_bad_stages
         $error("input_conditioner_channel: STAGES must be >= 2");
      end
      if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
         $error("input_conditioner_channel: DEBOUNCE_CYCLES must be >= 1");
      end
   endgenerate

   logic [STAGES-1:0] sync_q, sync_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              level_q, level_d;
   logic              rise_q, rise_d;
   logic              fall_q, fall_d;
   logic              sync;
   logic              accept;

   always_comb begin
      sync_d  = {sync_q[STAGES-2:0], in};
      sync    = sync_q[STAGES-1];
      accept  = (sync != level_q) && (cnt_q == CNT_MAX);
      cnt_d   = cnt_q;
      level_d = level_q;
      // Any return to the current level before acceptance discards the count.
      if (sync == level_q) begin
         cnt_d = '0;
      end else if (accept) begin
         level_d = sync;
         cnt_d   = '0;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      rise_d = sync & ~level_q & accept;
      fall_d = ~sync & level_q & accept;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign level = level_q;
   assign rise  = rise_q;
   assign fall  = fall_q;

endmodule

`default_nettype wire

// File: rtl/input_conditioner.sv
// ---------------------------------------------------------------------------
// input_conditioner : multi-channel synchroniser, debouncer and edge detector
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module input_conditioner
   import tow_pkg::*;
#(
   parameter int CHANNELS        = 2,
   parameter int STAGES          = TOW_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = TOW_DEBOUNCE_CYCLES
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] in,
   output logic [CHANNELS-1:0] level,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall
);

   generate
      if (CHANNELS < 1) begin : g_bad_channels
         $error("input_conditioner: CHANNELS must be >= 1");
      end

      for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
         input_conditioner_channel #(
            .STAGES          (STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_channel (
            .clk   (clk),
            .reset (reset),
            .in    (in[i]),
            .level (level[i]),
            .rise  (rise[i]),
            .fall  (fall[i])
         );
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_input_conditioner : scoreboard bench for input_conditioner (defaults and
// a CHANNELS=4 / STAGES=3 / DEBOUNCE_CYCLES=1 instance)
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_input_conditioner;

   typedef struct {
      int due;
      int ch;
      bit is_rise;
   } pulse_t;

   typedef struct {
      int         due;
      logic [3:0] lvl;
      logic [3:0] r;
      logic [3:0] f;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] in_a, level_a, rise_a, fall_a;
   logic [3:0] in_b, level_b, rise_b, fall_b;

   int edge_cnt = 0;
   int n_tests  = 0;
   int n_fail   = 0;

   pulse_t q_pulse[$];
   vec_t   q_vec[$];

   input_conditioner u_dut_a (
      .clk   (clk),
      .reset (reset),
      .in    (in_a),
      .level (level_a),
      .rise  (rise_a),
      .fall  (fall_a)
   );

   input_conditioner #(
      .CHANNELS        (4),
      .STAGES          (3),
      .DEBOUNCE_CYCLES (1)
   ) u_dut_b (
      .clk   (clk),
      .reset (reset),
      .in    (in_b),
      .level (level_b),
      .rise  (rise_b),
      .fall  (fall_b)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
      end
   endtask

   task automatic push_pulse(input int due, input int ch, input bit is_rise);
      pulse_t p;
      p.due     = due;
      p.ch      = ch;
      p.is_rise = is_rise;
      q_pulse.push_back(p);
   endtask

   // Drive at the negedge; s is the number of the posedge that samples it.
   task automatic drive_a(input logic [1:0] v, output int s);
      @(negedge clk);
      in_a = v;
      s    = edge_cnt + 1;
   endtask

   task automatic wait_edge(input int n);
      int g;
      g = 0;
      while (edge_cnt < n) begin
         @(posedge clk);
         #2;
         g++;
         if (g > 500) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_edge: got edge %0d expected edge %0d", edge_cnt, n);
            break;
         end
      end
   endtask

   // Monitor: pops expected pulses / vectors whenever the DUTs present them.
   initial begin
      forever begin
         @(posedge clk);
         edge_cnt++;
         #1;
         while (q_pulse.size() > 0 && q_pulse[0].due < edge_cnt) begin
            n_tests++;
            n_fail++;
            $display("FAIL missing_pulse: got none expected ch%0d %s at edge %0d",
                     q_pulse[0].ch, q_pulse[0].is_rise ? "rise" : "fall", q_pulse[0].due);
            void'(q_pulse.pop_front());
         end
         for (int ch = 0; ch < 2; ch++) begin
            if (rise_a[ch] && fall_a[ch]) begin
               n_tests++;
               n_fail++;
               $display("FAIL rise_fall_overlap: got both on ch%0d expected at most one", ch);
            end
            for (int k = 0; k < 2; k++) begin
               if ((k == 0) ? rise_a[ch] : fall_a[ch]) begin
                  n_tests++;
                  if (q_pulse.size() > 0 && q_pulse[0].due == edge_cnt &&
                      q_pulse[0].ch == ch && q_pulse[0].is_rise == (k == 0)) begin
                     void'(q_pulse.pop_front());
                  end else begin
                     n_fail++;
                     $display("FAIL unexpected_pulse: got ch%0d %s at edge %0d expected %s",
                              ch, (k == 0) ? "rise" : "fall", edge_cnt,
                              (q_pulse.size() > 0) ? "a different pulse" : "none");
                  end
               end
            end
         end
         while (q_vec.size() > 0 && q_vec[0].due <= edge_cnt) begin
            n_tests++;
            if (q_vec[0].due != edge_cnt ||
                {level_b, rise_b, fall_b} !== {q_vec[0].lvl, q_vec[0].r, q_vec[0].f}) begin
               n_fail++;
               $display("FAIL sweep edge %0d: got lvl=%h rise=%h fall=%h expected lvl=%h rise=%h fall=%h",
                        edge_cnt, level_b, rise_b, fall_b, q_vec[0].lvl, q_vec[0].r, q_vec[0].f);
            end
            void'(q_vec.pop_front());
         end
      end
   end

   initial begin
      int s, t, f, e0;
      logic [3:0] prev, v;
      vec_t vec;

      reset = 1'b1;
      in_a  = 2'b11;
      in_b  = 4'b0000;
      repeat (3) @(negedge clk);
      check("reset_level", {2'b00, level_a}, 4'b0000);
      check("reset_rise",  {2'b00, rise_a},  4'b0000);
      check("reset_fall",  {2'b00, fall_a},  4'b0000);
      check("reset_level_b", level_b, 4'b0000);

      // Reset release with both inputs held high: rise on both channels at e0+5.
      reset = 1'b0;
      e0    = edge_cnt + 1;
      push_pulse(e0 + 5, 0, 1'b1);
      push_pulse(e0 + 5, 1, 1'b1);
      wait_edge(e0 + 4);
      check("rel_level_before", {2'b00, level_a}, 4'b0000);
      wait_edge(e0 + 5);
      check("rel_level_at",     {2'b00, level_a}, 4'b0011);
      check("rel_rise_at",      {2'b00, rise_a},  4'b0011);
      wait_edge(e0 + 6);
      check("rel_rise_after",   {2'b00, rise_a},  4'b0000);
      check("rel_level_after",  {2'b00, level_a}, 4'b0011);

      // Falling edge on both channels.
      drive_a(2'b00, s);
      push_pulse(s + 5, 0, 1'b0);
      push_pulse(s + 5, 1, 1'b0);
      wait_edge(s + 4);
      check("fall_level_before", {2'b00, level_a}, 4'b0011);
      wait_edge(s + 5);
      check("fall_level_at",     {2'b00, level_a}, 4'b0000);
      wait_edge(s + 7);

      // Three-cycle glitch on channel 0 is filtered.
      drive_a(2'b01, s);
      repeat (2) drive_a(2'b01, t);
      drive_a(2'b00, t);
      wait_edge(s + 10);
      check("glitch3_level", {2'b00, level_a}, 4'b0000);

      // Four-cycle pulse is accepted, then falls four cycles later.
      drive_a(2'b01, s);
      repeat (3) drive_a(2'b01, t);
      drive_a(2'b00, t);
      push_pulse(s + 5, 0, 1'b1);
      push_pulse(s + 9, 0, 1'b0);
      wait_edge(s + 4);
      check("glitch4_level_before", {2'b00, level_a}, 4'b0000);
      wait_edge(s + 5);
      check("glitch4_level_at",     {2'b00, level_a}, 4'b0001);
      wait_edge(s + 9);
      check("glitch4_level_fell",   {2'b00, level_a}, 4'b0000);
      wait_edge(s + 11);

      // Bounce on channel 1: 1,0,1,0 then held 1; one rise after the final 0->1.
      drive_a(2'b10, s);
      drive_a(2'b00, t);
      drive_a(2'b10, t);
      drive_a(2'b00, t);
      drive_a(2'b10, t);
      push_pulse(t + 5, 1, 1'b1);
      wait_edge(t + 4);
      check("bounce_level_before", {2'b00, level_a}, 4'b0000);
      wait_edge(t + 5);
      check("bounce_level_at",     {2'b00, level_a}, 4'b0010);
      drive_a(2'b00, t);
      push_pulse(t + 5, 1, 1'b0);
      wait_edge(t + 6);
      check("bounce_level_released", {2'b00, level_a}, 4'b0000);

      // Reset mid-count: counters restart from the first post-reset edge.
      drive_a(2'b01, s);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      check("midreset_level", {2'b00, level_a}, 4'b0000);
      check("midreset_rise",  {2'b00, rise_a},  4'b0000);
      @(negedge clk);
      reset = 1'b0;
      f     = edge_cnt + 1;
      push_pulse(f + 5, 0, 1'b1);
      wait_edge(f + 4);
      check("midreset_level_before", {2'b00, level_a}, 4'b0000);
      wait_edge(f + 5);
      check("midreset_level_at",     {2'b00, level_a}, 4'b0001);
      drive_a(2'b00, t);
      push_pulse(t + 5, 0, 1'b0);
      wait_edge(t + 6);

      // Parameter sweep instance: level follows the input three edges later.
      prev = 4'b0000;
      s    = 0;
      for (int i = 0; i < 44; i++) begin
         @(negedge clk);
         v    = (i < 40) ? 4'($urandom_range(0, 15)) : 4'b0000;
         in_b = v;
         s    = edge_cnt + 1;
         vec.due = s + 3;
         vec.lvl = v;
         vec.r   = v & ~prev;
         vec.f   = ~v & prev;
         q_vec.push_back(vec);
         prev = v;
      end
      wait_edge(s + 4);

      repeat (3) @(negedge clk);
      while (q_pulse.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL leftover_pulse: got none expected ch%0d at edge %0d", q_pulse[0].ch, q_pulse[0].due);
         void'(q_pulse.pop_front());
      end
      while (q_vec.size() > 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL leftover_vector: got none expected vector at edge %0d", q_vec[0].due);
         void'(q_vec.pop_front());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/input_conditioner.md
# input_conditioner

Parametrised multi-channel input conditioner for asynchronous inputs such as player buttons and switches. Each channel is synchronised through a configurable-depth flip-flop chain, debounced by a per-channel stability counter, and edge-detected. Outputs are a clean level plus single-cycle rise and fall pulses. It sits between the board pins and the game FSM, replacing bare two-flop synchronisers.

## Interface

**Parameters**
- `CHANNELS`, default 2: number of independent input channels; must be ≥1.
- `STAGES`, default 2: synchroniser flip-flop depth; must be ≥2.
- `DEBOUNCE_CYCLES`, default 4: consecutive cycles a new synchronised value must persist before it is accepted; must be ≥1.
- Any illegal parameter value is an elaboration-time error (`$error`).

**Ports**
- `clk`, input, 1: system clock.
- `reset`, input, 1: asynchronous, active-high reset.
- `in`, input, `CHANNELS`: raw asynchronous inputs; bit i is channel i.
- `level`, output, `CHANNELS`: debounced, synchronised level.
- `rise`, output, `CHANNELS`: one-cycle pulse when `level[i]` goes 0→1.
- `fall`, output, `CHANNELS`: one-cycle pulse when `level[i]` goes 1→0.

## Operation

- Channels are fully independent; there is no cross-channel interaction.
- **Sync chain:** `STAGES` flops per channel, all reset to 0.
  - `s[0] <= in[i]`, then `s[k] <= s[k-1]`.
  - `sync = s[STAGES-1]`.
- **Debounce counter** `cnt`:
  - Width `$clog2(DEBOUNCE_CYCLES+1)`, reset to 0.
  - If `sync == level`: `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `level <= sync` and `cnt <= 0`.
  - Else: `cnt <= cnt + 1`.
  - `cnt` never exceeds `DEBOUNCE_CYCLES-1` and never wraps.
- **Glitch rejection:** if `sync` returns to `level` before acceptance, `cnt` clears. `level` is unchanged and no pulse is produced.
- **Edge pulses** are registered and update on the same edge as `level`:
  - `rise <= (sync & ~level & accept)`.
  - `fall <= (~sync & level & accept)`.
  - `accept` is the flip condition above.
  - Each pulse is high for exactly one cycle.
  - `rise` and `fall` of the same channel are never high together.
- **Reset values:** `level`, `rise`, `fall`, all sync flops and all counters are 0.
- **Reset mid-operation:**
  - Reset clears all state immediately, including in-flight counts and any pulse being asserted.
  - After deassertion, a held-high input produces `rise` only after the full latency below. No pulse is generated by reset itself.

## Timing

- An input change sampled at edge 0 reaches `sync` at edge `STAGES-1`.
- `level` and `rise`/`fall` update at edge `STAGES-1+DEBOUNCE_CYCLES`, if the value is held.
- With defaults: level change 5 edges after the first sampling edge.
- **Minimum accepted pulse width:** `DEBOUNCE_CYCLES` cycles at `sync`. Any shorter excursion is filtered.
- Toggle throughput: at most one level change per `DEBOUNCE_CYCLES` cycles per channel.
- With `DEBOUNCE_CYCLES=1`, any `sync` change is accepted on the next edge, so the block behaves as a pure synchroniser plus edge detector.
- Reset assertion is asynchronous; outputs go to 0 without waiting for a clock edge.

## Structure

- **Sub-module `input_conditioner_channel`:** one channel holding the sync chain, counter, level and pulse regs. It takes `STAGES` and `DEBOUNCE_CYCLES` as parameters and is instantiated `CHANNELS` times in a generate loop.
- **Shared package `tow_pkg`:** holds the default constants `TOW_SYNC_STAGES=2` and `TOW_DEBOUNCE_CYCLES`, so that top-level instances agree. No typedefs are needed.
- The counter width is a local `localparam` in the channel module.

## Test plan

- **Reset:** `in=2'b11` held with `reset=1` → `level=0`, `rise=0`, `fall=0`. Release reset at edge 0 → `rise[0]`=`rise[1]`=1 only in the cycle after edge 5, and `level=2'b11` from then on (defaults).
- **Glitch:** defaults, `in[0]` high for 3 cycles then low → `level[0]` stays 0 and `rise[0]` never asserts. Same stimulus for 4 cycles → `rise[0]` asserts for one cycle and `level[0]=1`.
- **Bounce:** `in[1]` toggles 1,0,1,0 each cycle, then held 1 → exactly one `rise[1]` pulse, 5 edges after the final 0→1 sample. `in[0]` is unaffected.
- **Falling edge:** `level[0]=1`, then `in[0]` low and held → one `fall[0]` pulse and `level[0]=0` 5 edges later. No `rise` occurs.
- **Reset mid-count:** `in[0]` rises, reset asserted 3 cycles later for 1 cycle → counters clear. `rise[0]` occurs 5 edges after the first post-reset edge, never earlier.
- **Parameter sweep:** `CHANNELS=4`, `STAGES=3`, `DEBOUNCE_CYCLES=1` → latency is 3 edges. Each channel is independent under random stimulus against a reference model.
